pulse_output_generator: RTL and testbench
=========================================

PULSE_OUTPUT_GENERATOR -- requirements
Module: pulse_output_generator

Interface
REQ-001 SHALL have parameter HIGH_CYCLES, default 4: pulse_out high time in clk cycles, legal range 1..65535.
REQ-002 SHALL have parameter LOW_CYCLES, default 2: minimum pulse_out low time between pulses in clk cycles, legal range 1..65535.
REQ-003 SHALL have parameter PEND_MAX, default 15: maximum queued triggers, legal range 1..255; PW = $clog2(PEND_MAX+1).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  1 = accept triggers; 0 = ignore triggers and flush the queue.
REQ-007 SHALL have port trigger  input  1  single-cycle event strobe (for example, a rising-edge detect); each high cycle is one request.
REQ-008 SHALL have port clear_overflow  input  1  clears the overflow flag.
REQ-009 SHALL have port pulse_out  output  1  registered, glitch-free output pulse.
REQ-010 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-011 SHALL have port pending_count  output  PW  number of triggers queued and not yet started.
REQ-012 SHALL have port overflow  output  1  sticky; set when a trigger is dropped.

Function
REQ-013 SHALL implement FSM states IDLE, HIGH, LOW; pulse_out = 1 only in HIGH, driven from a register.
REQ-014 IDLE with enable=1, trigger=1 at edge N SHALL enter HIGH; pulse_out high from cycle N+1; pending_count unchanged.
REQ-015 HIGH SHALL last exactly HIGH_CYCLES cycles, then enter LOW.
REQ-016 LOW SHALL last exactly LOW_CYCLES cycles; at exit, if pending_count>0 and enable=1, enter HIGH and decrement pending_count, else enter IDLE.
REQ-017 A trigger with enable=1 in HIGH or LOW SHALL increment pending_count if pending_count<PEND_MAX, else be dropped and set overflow.
REQ-018 A trigger accepted in the same cycle as a dequeue SHALL leave pending_count unchanged; the trigger is never dropped in that case.
REQ-019 With enable=0, triggers SHALL be ignored and pending_count cleared next cycle; an in-progress HIGH/LOW sequence SHALL complete fully (no truncated pulse), then go to IDLE.
REQ-020 clear_overflow=1 SHALL clear overflow next cycle; if a drop occurs in the same cycle, set SHALL win.
REQ-021 Cycle timer SHALL load HIGH_CYCLES-1 / LOW_CYCLES-1 on state entry and count down to 0; width = $clog2(max(HIGH_CYCLES,LOW_CYCLES)), minimum 1.
REQ-022 Back-to-back queued pulses SHALL have period exactly HIGH_CYCLES+LOW_CYCLES.

Reset
REQ-023 reset=1 at a rising edge SHALL force state=IDLE, pulse_out=0, busy=0, pending_count=0, overflow=0, timer=0.
REQ-024 reset SHALL override all other inputs, including mid-pulse; pulse_out SHALL be 0 in the cycle after reset is sampled.
REQ-025 The first trigger SHALL be honoured at the first edge with reset=0.

Structure
REQ-026 Package pulse_gen_pkg SHALL hold the state enum (IDLE, HIGH, LOW) and the default constants for HIGH_CYCLES, LOW_CYCLES and PEND_MAX.
REQ-027 One sub-module, cycle_timer (loadable down-counter with a zero flag), SHALL provide the HIGH/LOW timing; the FSM and queue counter stay in the top level.

Verification
REQ-028 Defaults; single trigger at cycle 10 -> pulse_out high cycles 11-14, low from 15, busy low from cycle 17.
REQ-029 Triggers at cycles 10, 11, 12 -> three pulses starting at cycles 11, 17, 23; pending_count peaks at 2.
REQ-030 PEND_MAX=2; five triggers during the first pulse -> 2 queued, 3 dropped, overflow=1; clear_overflow -> overflow=0 next cycle.
REQ-031 Trigger and clear_overflow in the same cycle as a forced drop -> overflow stays 1; trigger coincident with a dequeue -> pending_count unchanged.
REQ-032 enable=0 during the second of three queued pulses -> that pulse completes 4 high / 2 low, the queue flushes to 0, FSM returns to IDLE.
REQ-033 reset asserted mid-HIGH with pending_count=3 -> next cycle pulse_out=0, pending_count=0, busy=0, overflow=0.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the pulse output generator.
//   state_t         : FSM state encoding (IDLE, HIGH, LOW)
//   DEF_*           : default parameter values for the top level
//   timer_width()   : bit width needed by the phase timer
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int unsigned DEF_HIGH_CYCLES = 4;
  localparam int unsigned DEF_LOW_CYCLES  = 2;
  localparam int unsigned DEF_PEND_MAX    = 15;

  // Width holding max(high, low) - 1, never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned high_cycles,
                                              input int unsigned low_cycles);
    int unsigned longest;
    int unsigned width;
    longest = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    width   = $clog2(longest);
    if (width < 1) width = 1;
    return width;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter used to time the HIGH and LOW phases.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset, clears the count
//   load       : load load_value this cycle (wins over counting)
//   load_value : phase length minus one
//   zero_c     : count has reached zero (combinational from the count register)
module cycle_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  // Count down and park at zero until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/pulse_output_generator.sv
// Turns single-cycle trigger strobes into fixed-width output pulses with a
// guaranteed low gap, queueing triggers that arrive while a pulse is running.
//   clk            : clock, rising edge
//   reset          : synchronous active-high reset, overrides everything
//   enable         : 1 = accept triggers, 0 = ignore triggers and flush queue
//   trigger        : one request per high cycle
//   clear_overflow : clears the sticky overflow flag
//   pulse_out      : registered pulse, high only in HIGH
//   busy           : registered, high whenever the FSM is not IDLE
//   pending_count  : queued triggers not yet started
//   overflow       : sticky, set when a trigger is dropped on a full queue
module pulse_output_generator
  import pulse_gen_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int unsigned LOW_CYCLES  = DEF_LOW_CYCLES,
  parameter int unsigned PEND_MAX    = DEF_PEND_MAX
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             trigger,
  input  logic                             clear_overflow,
  output logic                             pulse_out,
  output logic                             busy,
  output logic [$clog2(PEND_MAX+1)-1:0]    pending_count,
  output logic                             overflow
);

  localparam int unsigned PW = $clog2(PEND_MAX + 1);
  localparam int unsigned TW = timer_width(HIGH_CYCLES, LOW_CYCLES);

  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

  state_t          state;
  state_t          state_next;
  logic            timer_zero_c;
  logic            timer_load_c;
  logic [TW-1:0]   timer_value_c;
  logic            pulse_out_d;
  logic            busy_d;
  logic            pend_nonzero_c;
  logic            pend_full_c;
  logic            deq_c;
  logic            enq_c;
  logic            drop_c;

  assign pend_nonzero_c = (pending_count != '0);
  assign pend_full_c    = (pending_count >= PEND_FULL);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. IDLE also starts from a non-empty queue: a trigger
  // arriving on the final LOW cycle of an empty queue is queued while the
  // FSM drops to IDLE, and must still be serviced.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable && (trigger || pend_nonzero_c)) state_next = HIGH;
      end
      HIGH: begin
        if (timer_zero_c) state_next = LOW;
      end
      LOW: begin
        if (timer_zero_c) state_next = (enable && pend_nonzero_c) ? HIGH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / timer-control logic, decoded from the state being entered so
  // the registered outputs line up with the state register.
  always_comb begin
    pulse_out_d   = (state_next == HIGH);
    busy_d        = (state_next != IDLE);
    timer_load_c  = (state_next != state) && (state_next != IDLE);
    timer_value_c = (state_next == HIGH) ? HIGH_LOAD : LOW_LOAD;
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pulse_out <= pulse_out_d;
      busy      <= busy_d;
    end
  end

  // A pulse started from the queue consumes one entry; a trigger that itself
  // starts a pulse from an empty IDLE is never queued.
  assign deq_c  = enable && pend_nonzero_c && (state_next == HIGH) && (state != HIGH);
  assign enq_c  = enable && trigger && !((state == IDLE) && !pend_nonzero_c);
  assign drop_c = enq_c && !deq_c && pend_full_c;

  // Pending-trigger counter.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pending_count <= '0;
    end else if (enq_c && !deq_c && !pend_full_c) begin
      pending_count <= pending_count + PW'(1);
    end else if (deq_c && !enq_c) begin
      pending_count <= pending_count - PW'(1);
    end
  end

  // Sticky overflow; a drop in the same cycle beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  cycle_timer #(
    .WIDTH (TW)
  ) u_cycle_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load_c),
    .load_value (timer_value_c),
    .zero_c     (timer_zero_c)
  );

endmodule

// File: tb/tb_pulse_output_generator.sv
// Bench for pulse_output_generator: four parameterisations driven by the
// same inputs, directed scenarios plus a randomized run against a cycle
// model built from the pulse/queue rules.
module tb_pulse_output_generator;

  localparam int NI = 4;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       trigger;
  logic       clear_overflow;
  logic [3:0] po;
  logic [3:0] bz;
  logic [3:0] ov;
  logic [3:0] pc0;
  logic [1:0] pc1;
  logic [0:0] pc2;
  logic [2:0] pc3;

  int P_H [NI] = '{4, 4, 1, 3};
  int P_L [NI] = '{2, 2, 1, 5};
  int P_Q [NI] = '{15, 2, 1, 4};

  int m_mode [NI];
  int m_el   [NI];
  int m_pend [NI];
  bit m_ovf  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  pulse_output_generator dut0 (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
    .clear_overflow(clear_overflow), .pulse_out(po[0]), .busy(bz[0]),
    .pending_count(pc0), .overflow(ov[0]));

  pulse_output_generator #(.HIGH_CYCLES(4), .LOW_CYCLES(2), .PEND_MAX(2)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
    .clear_overflow(clear_overflow), .pulse_out(po[1]), .busy(bz[1]),
    .pending_count(pc1), .overflow(ov[1]));

  pulse_output_generator #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .PEND_MAX(1)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
    .clear_overflow(clear_overflow), .pulse_out(po[2]), .busy(bz[2]),
    .pending_count(pc2), .overflow(ov[2]));

  pulse_output_generator #(.HIGH_CYCLES(3), .LOW_CYCLES(5), .PEND_MAX(4)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
    .clear_overflow(clear_overflow), .pulse_out(po[3]), .busy(bz[3]),
    .pending_count(pc3), .overflow(ov[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int dut_pend(input int i);
    case (i)
      0: return int'(pc0);
      1: return int'(pc1);
      2: return int'(pc2);
      default: return int'(pc3);
    endcase
  endfunction

  // Model: mode 0 idle / 1 high / 2 low, el = cycles already spent in phase.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int mode;
      int el;
      int pend;
      int npend;
      bit fin;
      bit taken;
      bit arriving;
      bit drop;
      mode = m_mode[i];
      el   = m_el[i];
      pend = m_pend[i];
      if (reset) begin
        m_mode[i] = 0;
        m_el[i]   = 0;
        m_pend[i] = 0;
        m_ovf[i]  = 1'b0;
      end else begin
        fin      = (mode == 1 && el + 1 >= P_H[i]) || (mode == 2 && el + 1 >= P_L[i]);
        taken    = 1'b0;
        arriving = enable && trigger && !(mode == 0 && pend == 0);
        m_el[i]  = el + 1;
        if (mode == 0) begin
          m_el[i] = 0;
          if (enable && (trigger || pend > 0)) begin
            m_mode[i] = 1;
            taken = (pend > 0);
          end
        end else if (fin) begin
          m_el[i] = 0;
          if (mode == 1) m_mode[i] = 2;
          else if (enable && pend > 0) begin
            m_mode[i] = 1;
            taken = 1'b1;
          end else m_mode[i] = 0;
        end
        npend = pend - (taken ? 1 : 0) + (arriving ? 1 : 0);
        drop  = enable && (npend > P_Q[i]);
        if (!enable) npend = 0;
        else if (drop) npend = P_Q[i];
        m_pend[i] = npend;
        if (drop) m_ovf[i] = 1'b1;
        else if (clear_overflow) m_ovf[i] = 1'b0;
      end
    end
  endtask

  // One clock: the model consumes the inputs seen at the edge, outputs are
  // then read 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; trigger = 1'b0; clear_overflow = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; trigger = 1'b1; clear_overflow = 1'b0;
    tick();
    tick();
    n_tests++;
    if (po !== 4'b0000) begin n_fail++; $display("FAIL reset_pulse got %b exp 0000", po); end
    n_tests++;
    if (bz !== 4'b0000) begin n_fail++; $display("FAIL reset_busy got %b exp 0000", bz); end
    n_tests++;
    if (ov !== 4'b0000) begin n_fail++; $display("FAIL reset_overflow got %b exp 0000", ov); end
    n_tests++;
    if ({pc0, pc1, pc2, pc3} !== 10'd0)
      begin n_fail++; $display("FAIL reset_pending got %h exp 0", {pc0, pc1, pc2, pc3}); end
    reset = 1'b0;
    tick();
    n_tests++;
    if (po !== 4'b1111) begin n_fail++; $display("FAIL first_trigger_after_reset got %b exp 1111", po); end
    trigger = 1'b0;
    for (int k = 0; k < 20; k++) tick();
  endtask

  task automatic test_single();
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      trigger = (k == 1);
      tick();
      n_tests++;
      if (po[0] !== (k <= 4)) begin n_fail++; $display("FAIL single_pulse k=%0d got %b exp %b", k, po[0], k <= 4); end
      n_tests++;
      if (bz[0] !== (k <= 6)) begin n_fail++; $display("FAIL single_busy k=%0d got %b exp %b", k, bz[0], k <= 6); end
      n_tests++;
      if (pc0 !== 4'd0) begin n_fail++; $display("FAIL single_pending k=%0d got %0d exp 0", k, pc0); end
      n_tests++;
      if (po[2] !== (k == 1)) begin n_fail++; $display("FAIL single_h1_pulse k=%0d got %b exp %b", k, po[2], k == 1); end
      n_tests++;
      if (bz[2] !== (k <= 2)) begin n_fail++; $display("FAIL single_h1_busy k=%0d got %b exp %b", k, bz[2], k <= 2); end
    end
  endtask

  task automatic test_back_to_back();
    int maxp;
    bit exp_po;
    maxp = 0;
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      trigger = (k <= 3);
      tick();
      exp_po = (k <= 16) && (((k - 1) % 6) < 4);
      n_tests++;
      if (po[0] !== exp_po) begin n_fail++; $display("FAIL b2b_pulse k=%0d got %b exp %b", k, po[0], exp_po); end
      n_tests++;
      if (bz[0] !== (k <= 18)) begin n_fail++; $display("FAIL b2b_busy k=%0d got %b exp %b", k, bz[0], k <= 18); end
      if (int'(pc0) > maxp) maxp = int'(pc0);
    end
    trigger = 1'b0;
    n_tests++;
    if (maxp != 2) begin n_fail++; $display("FAIL b2b_pending_peak got %0d exp 2", maxp); end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      trigger = (k <= 6) || (k == 8) || (k == 9) || (k == 13);
      clear_overflow = (k == 7) || (k == 9);
      tick();
      if (k == 3) begin
        n_tests++;
        if (ov[1] !== 1'b0 || pc1 !== 2'd2)
          begin n_fail++; $display("FAIL ovf_fill got ov=%b pend=%0d exp ov=0 pend=2", ov[1], pc1); end
      end
      if (k == 4) begin
        n_tests++;
        if (ov[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_first_drop got %b exp 1", ov[1]); end
      end
      if (k == 6) begin
        n_tests++;
        if (ov[1] !== 1'b1 || pc1 !== 2'd2)
          begin n_fail++; $display("FAIL ovf_after_drops got ov=%b pend=%0d exp ov=1 pend=2", ov[1], pc1); end
      end
      if (k == 7) begin
        n_tests++;
        if (ov[1] !== 1'b0 || pc1 !== 2'd1)
          begin n_fail++; $display("FAIL ovf_clear got ov=%b pend=%0d exp ov=0 pend=1", ov[1], pc1); end
      end
      if (k == 9) begin
        n_tests++;
        if (ov[1] !== 1'b1 || pc1 !== 2'd2)
          begin n_fail++; $display("FAIL ovf_set_beats_clear got ov=%b pend=%0d exp ov=1 pend=2", ov[1], pc1); end
      end
      if (k == 13) begin
        n_tests++;
        if (pc1 !== 2'd2 || po[1] !== 1'b1 || ov[1] !== 1'b1)
          begin n_fail++; $display("FAIL ovf_enq_with_deq got pend=%0d po=%b ov=%b exp 2 1 1", pc1, po[1], ov[1]); end
      end
    end
    trigger = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic test_enable_flush();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      trigger = (k <= 3) || (k == 9) || (k == 10);
      enable = (k < 8);
      tick();
      if (k == 7) begin
        n_tests++;
        if (pc0 !== 4'd1) begin n_fail++; $display("FAIL en_second_start_pend got %0d exp 1", pc0); end
      end
      if (k >= 7) begin
        n_tests++;
        if (po[0] !== (k <= 10)) begin n_fail++; $display("FAIL en_pulse k=%0d got %b exp %b", k, po[0], k <= 10); end
        n_tests++;
        if (bz[0] !== (k <= 12)) begin n_fail++; $display("FAIL en_busy k=%0d got %b exp %b", k, bz[0], k <= 12); end
      end
      if (k >= 8) begin
        n_tests++;
        if (pc0 !== 4'd0) begin n_fail++; $display("FAIL en_flush k=%0d got %0d exp 0", k, pc0); end
      end
    end
    trigger = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      trigger = (k <= 6);
      reset = (k == 5);
      tick();
      if (k == 4) begin
        n_tests++;
        if (pc0 !== 4'd3 || po[0] !== 1'b1 || ov[1] !== 1'b1)
          begin n_fail++; $display("FAIL mid_setup got pend=%0d po=%b ov1=%b exp 3 1 1", pc0, po[0], ov[1]); end
      end
      if (k == 5) begin
        n_tests++;
        if (po !== 4'b0000 || bz !== 4'b0000 || ov !== 4'b0000 || pc0 !== 4'd0)
          begin n_fail++; $display("FAIL mid_reset got po=%b bz=%b ov=%b pend=%0d exp all 0", po, bz, ov, pc0); end
      end
      if (k == 6) begin
        n_tests++;
        if (po[0] !== 1'b1 || pc0 !== 4'd0)
          begin n_fail++; $display("FAIL mid_restart got po=%b pend=%0d exp 1 0", po[0], pc0); end
      end
    end
    reset = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic test_random();
    int thr;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      thr = (c < 1000) ? 40 : (c < 2000) ? 12 : 85;
      enable         = ($urandom_range(0, 9) != 0);
      trigger        = ($urandom_range(0, 99) < thr);
      clear_overflow = ($urandom_range(0, 19) == 0);
      reset          = ($urandom_range(0, 199) == 0);
      tick();
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (po[i] !== (m_mode[i] == 1))
          begin n_fail++; $display("FAIL rand_pulse dut%0d c=%0d got %b exp %b", i, c, po[i], m_mode[i] == 1); end
        n_tests++;
        if (bz[i] !== (m_mode[i] != 0))
          begin n_fail++; $display("FAIL rand_busy dut%0d c=%0d got %b exp %b", i, c, bz[i], m_mode[i] != 0); end
        n_tests++;
        if (dut_pend(i) != m_pend[i])
          begin n_fail++; $display("FAIL rand_pending dut%0d c=%0d got %0d exp %0d", i, c, dut_pend(i), m_pend[i]); end
        n_tests++;
        if (ov[i] !== m_ovf[i])
          begin n_fail++; $display("FAIL rand_overflow dut%0d c=%0d got %b exp %b", i, c, ov[i], m_ovf[i]); end
      end
    end
    reset = 1'b0;
    trigger = 1'b0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    trigger = 1'b0;
    clear_overflow = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_mode[i] = 0; m_el[i] = 0; m_pend[i] = 0; m_ovf[i] = 1'b0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_enable_flush();
    test_reset_mid_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
